// File: rtl/memory_access_pkg.sv
// rtl/memory_access_pkg.sv - shared types and op helpers for the MEM stage
package memory_access_pkg;

  localparam int BUS_BYTES = 8;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef enum logic [3:0] {
    OP_ALU = 4'd0,
    OP_LB  = 4'd1,
    OP_LH  = 4'd2,
    OP_LW  = 4'd3,
    OP_LD  = 4'd4,
    OP_LBU = 4'd5,
    OP_LHU = 4'd6,
    OP_LWU = 4'd7,
    OP_SB  = 4'd8,
    OP_SH  = 4'd9,
    OP_SW  = 4'd10,
    OP_SD  = 4'd11
  } decoded_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } mem_state_t;

  typedef struct packed {
    decoded_op_t op;
    logic        regWrite;
    logic        csrWrite;
    logic        mem_is_store;
    logic        misalign;
  } control_t;

  typedef struct packed {
    logic [63:0] pc;
    control_t    ctl;
    logic [4:0]  dst;
    logic [63:0] mem_addr;
    logic [63:0] result;
    logic [11:0] csr_addr;
    logic [63:0] csr_result;
    logic        is_ecall;
    logic        is_mret;
  } execute_data_t;

  typedef struct packed {
    logic [63:0] pc;
    control_t    ctl;
    logic [4:0]  dst;
    logic [63:0] result;
    logic [11:0] csr_addr;
    logic [63:0] csr_result;
    logic        is_ecall;
    logic        is_mret;
  } memory_data_t;

  typedef struct packed {
    logic                 valid;
    logic [63:0]          addr;
    msize_t               size;
    logic [BUS_BYTES-1:0] strobe;
    logic [63:0]          data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  function automatic logic is_load(decoded_op_t op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU};
  endfunction

  function automatic logic is_store(decoded_op_t op);
    return op inside {OP_SB, OP_SH, OP_SW, OP_SD};
  endfunction

  function automatic msize_t op_msize(decoded_op_t op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return MSIZE1;
      OP_LH, OP_LHU, OP_SH: return MSIZE2;
      OP_LW, OP_LWU, OP_SW: return MSIZE4;
      default:              return MSIZE8;
    endcase
  endfunction

  // Pass-through view of an EX bundle; the access-type flags are recomputed here, never trusted from EX.
  function automatic memory_data_t to_memory_data(execute_data_t e);
    memory_data_t m;
    m.pc               = e.pc;
    m.ctl.op           = e.ctl.op;
    m.ctl.regWrite     = e.ctl.regWrite;
    m.ctl.csrWrite     = e.ctl.csrWrite;
    m.ctl.mem_is_store = is_store(e.ctl.op);
    m.ctl.misalign     = 1'b0;
    m.dst              = e.dst;
    m.result           = e.result;
    m.csr_addr         = e.csr_addr;
    m.csr_result       = e.csr_result;
    m.is_ecall         = e.is_ecall;
    m.is_mret          = e.is_mret;
    return m;
  endfunction

endpackage

// File: rtl/memory_access_mem_align.sv
// rtl/memory_access_mem_align.sv - store lane/strobe shaping, load extraction, misalign detect
import memory_access_pkg::*;

module mem_align (
  input  decoded_op_t  op,
  input  logic [2:0]   offset,
  input  logic [63:0]  storeData,
  input  logic [63:0]  loadData,
  output msize_t       size,
  output logic [7:0]   strobe,
  output logic [63:0]  storeLanes,
  output logic [63:0]  loadResult,
  output logic         misaligned
);

  logic [5:0]  shamt;
  logic [63:0] lane;
  logic [63:0] replicated;
  logic [7:0]  mask;

  assign shamt = {offset, 3'b000};
  assign lane  = loadData >> shamt;

  always_comb begin
    size       = op_msize(op);
    replicated = storeData;
    mask       = 8'hff;
    misaligned = 1'b0;
    unique case (size)
      MSIZE1: begin
        replicated = {8{storeData[7:0]}};
        mask       = 8'h01;
      end
      MSIZE2: begin
        replicated = {4{storeData[15:0]}};
        mask       = 8'h03;
        misaligned = offset[0];
      end
      MSIZE4: begin
        replicated = {2{storeData[31:0]}};
        mask       = 8'h0f;
        misaligned = |offset[1:0];
      end
      MSIZE8: begin
        replicated = storeData;
        mask       = 8'hff;
        misaligned = |offset;
      end
    endcase
    if (!(is_load(op) || is_store(op))) misaligned = 1'b0;
  end

  // Doubleword strobe stays full; narrower masks shift and anything past byte 7 falls off.
  always_comb begin
    strobe     = 8'h00;
    storeLanes = 64'd0;
    if (is_store(op)) begin
      strobe     = (size == MSIZE8) ? 8'hff : (mask << offset);
      storeLanes = replicated << shamt;
    end
  end

  always_comb begin
    loadResult = lane;
    case (op)
      OP_LB:   loadResult = {{56{lane[7]}}, lane[7:0]};
      OP_LH:   loadResult = {{48{lane[15]}}, lane[15:0]};
      OP_LW:   loadResult = {{32{lane[31]}}, lane[31:0]};
      OP_LBU:  loadResult = {56'd0, lane[7:0]};
      OP_LHU:  loadResult = {48'd0, lane[15:0]};
      OP_LWU:  loadResult = {32'd0, lane[31:0]};
      default: loadResult = lane;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// rtl/memory_access.sv - MEM stage: one dbus transaction per load/store, stalls until data_ok
// Optional build macro MISALIGN_TRAP_EN turns misaligned accesses into a 1-cycle trap report.
import memory_access_pkg::*;

module memory_access (
  input  logic          clk,
  input  logic          reset,
  input  execute_data_t dataE,
  input  logic          valid_in,
  input  logic          flush,
  output dbus_req_t     dreq,
  input  dbus_resp_t    dresp,
  output logic          mem_stall,
  output memory_data_t  dataM,
  output logic          valid_out
);

  mem_state_t   state;
  memory_data_t pendM;
  logic [63:0]  reqAddr;
  msize_t       reqSize;
  logic [7:0]   reqStrobe;
  logic [63:0]  reqData;

  logic         idle;
  logic         isMemIn;
  logic         accept;
  logic         trapIn;
  logic         startReq;
  decoded_op_t  alignOp;
  logic [2:0]   alignOff;
  msize_t       alignSize;
  logic [7:0]   alignStrobe;
  logic [63:0]  alignLanes;
  logic [63:0]  alignLoad;
  logic         misaligned;
  memory_data_t retireM;
  memory_data_t trapM;

  assign idle    = (state == IDLE);
  assign isMemIn = is_load(dataE.ctl.op) || is_store(dataE.ctl.op);
  assign accept  = idle && valid_in && !flush;

  // One aligner: it shapes the incoming request in IDLE and extracts the load once the bus is busy.
  assign alignOp  = idle ? dataE.ctl.op : pendM.ctl.op;
  assign alignOff = idle ? dataE.mem_addr[2:0] : reqAddr[2:0];

  mem_align u_align (
    .op         (alignOp),
    .offset     (alignOff),
    .storeData  (dataE.result),
    .loadData   (dresp.data),
    .size       (alignSize),
    .strobe     (alignStrobe),
    .storeLanes (alignLanes),
    .loadResult (alignLoad),
    .misaligned (misaligned)
  );

`ifdef MISALIGN_TRAP_EN
  logic unusedBits;
  assign unusedBits = ^{dresp.addr_ok, dataE.ctl.mem_is_store, dataE.ctl.misalign};
  assign trapIn = isMemIn && misaligned;
  always_comb begin
    trapM              = to_memory_data(dataE);
    trapM.ctl.misalign = 1'b1;
    trapM.ctl.regWrite = 1'b0;
    trapM.result       = dataE.mem_addr;
  end
`else
  logic unusedBits;
  assign unusedBits = ^{dresp.addr_ok, dataE.ctl.mem_is_store, dataE.ctl.misalign, misaligned};
  assign trapIn = 1'b0;
  assign trapM  = to_memory_data(dataE);
`endif

  assign startReq  = accept && isMemIn && !trapIn;
  assign mem_stall = startReq || !idle;

  always_comb begin
    retireM = pendM;
    if (is_load(pendM.ctl.op)) retireM.result = alignLoad;
  end

  always_comb begin
    dreq = '0;
    if (!idle) begin
      dreq.valid  = 1'b1;
      dreq.addr   = reqAddr;
      dreq.size   = reqSize;
      dreq.strobe = reqStrobe;
      dreq.data   = reqData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pendM     <= '0;
      reqAddr   <= '0;
      reqSize   <= MSIZE1;
      reqStrobe <= '0;
      reqData   <= '0;
      dataM     <= '0;
      valid_out <= 1'b0;
    end else begin
      dataM     <= '0;
      valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (trapIn) begin
              dataM     <= trapM;
              valid_out <= 1'b1;
            end else if (isMemIn) begin
              state     <= BUSY;
              pendM     <= to_memory_data(dataE);
              reqAddr   <= dataE.mem_addr;
              reqSize   <= alignSize;
              reqStrobe <= alignStrobe;
              reqData   <= alignLanes;
            end else begin
              dataM     <= to_memory_data(dataE);
              valid_out <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (dresp.data_ok) begin
            state <= IDLE;
            if (!flush) begin
              dataM     <= retireM;
              valid_out <= 1'b1;
            end
          end else if (flush) begin
            state <= DRAIN;
          end
        end
        // Request stays up until the bus answers; the answer is thrown away.
        DRAIN: begin
          if (dresp.data_ok) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// tb/tb_memory_access.sv - randomized self-checking bench for memory_access
import memory_access_pkg::*;

module tb_memory_access;

  logic          clk;
  logic          reset;
  execute_data_t dataE;
  logic          valid_in;
  logic          flush;
  dbus_req_t     dreq;
  dbus_resp_t    dresp;
  logic          mem_stall;
  memory_data_t  dataM;
  logic          valid_out;

  int total = 0;
  int bad   = 0;

  memory_access dut (
    .clk       (clk),
    .reset     (reset),
    .dataE     (dataE),
    .valid_in  (valid_in),
    .flush     (flush),
    .dreq      (dreq),
    .dresp     (dresp),
    .mem_stall (mem_stall),
    .dataM     (dataM),
    .valid_out (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic mIsLd(decoded_op_t op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) || (op == OP_LD) ||
           (op == OP_LBU) || (op == OP_LHU) || (op == OP_LWU);
  endfunction

  function automatic logic mIsSt(decoded_op_t op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW) || (op == OP_SD);
  endfunction

  function automatic int mBytes(decoded_op_t op);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    if (op == OP_LW || op == OP_LWU || op == OP_SW) return 4;
    return 8;
  endfunction

  function automatic msize_t mSize(decoded_op_t op);
    int n = mBytes(op);
    if (n == 1) return MSIZE1;
    if (n == 2) return MSIZE2;
    if (n == 4) return MSIZE4;
    return MSIZE8;
  endfunction

  function automatic logic [7:0] mStrobe(decoded_op_t op, logic [63:0] addr);
    logic [7:0] s = 8'h00;
    int off = int'(addr[2:0]);
    int n = mBytes(op);
    if (!mIsSt(op)) return 8'h00;
    if (n == 8) return 8'hff;
    for (int i = 0; i < 8; i++)
      if (i >= off && i < off + n) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] mStoreData(decoded_op_t op, logic [63:0] addr, logic [63:0] d);
    logic [63:0] r = 64'd0;
    int off = int'(addr[2:0]);
    int n = mBytes(op);
    if (!mIsSt(op)) return 64'd0;
    for (int i = 0; i < 8; i++)
      if (i >= off) r[i*8 +: 8] = d[((i - off) % n)*8 +: 8];
    return r;
  endfunction

  function automatic logic [63:0] mLoad(decoded_op_t op, logic [63:0] addr, logic [63:0] d);
    logic [63:0] v = 64'd0;
    int off = int'(addr[2:0]);
    int n = mBytes(op);
    logic sgn;
    for (int j = 0; j < n; j++)
      if (off + j < 8) v[j*8 +: 8] = d[(off + j)*8 +: 8];
    sgn = (op == OP_LB) || (op == OP_LH) || (op == OP_LW);
    if (sgn && n < 8 && v[n*8-1]) v = v | ~((64'd1 << (n*8)) - 64'd1);
    return v;
  endfunction

  function automatic memory_data_t mRetire(execute_data_t e, logic [63:0] rdata);
    memory_data_t m;
    m = '0;
    m.pc               = e.pc;
    m.ctl.op           = e.ctl.op;
    m.ctl.regWrite     = e.ctl.regWrite;
    m.ctl.csrWrite     = e.ctl.csrWrite;
    m.ctl.mem_is_store = mIsSt(e.ctl.op);
    m.ctl.misalign     = 1'b0;
    m.dst              = e.dst;
    m.result           = mIsLd(e.ctl.op) ? mLoad(e.ctl.op, e.mem_addr, rdata) : e.result;
    m.csr_addr         = e.csr_addr;
    m.csr_result       = e.csr_result;
    m.is_ecall         = e.is_ecall;
    m.is_mret          = e.is_mret;
    return m;
  endfunction

  function automatic execute_data_t mkInstr(decoded_op_t op, logic [63:0] addr, logic [63:0] res);
    execute_data_t e;
    e.pc               = {$urandom(), $urandom()};
    e.ctl.op           = op;
    e.ctl.regWrite     = 1'($urandom_range(0, 1));
    e.ctl.csrWrite     = 1'($urandom_range(0, 1));
    e.ctl.mem_is_store = 1'($urandom_range(0, 1));
    e.ctl.misalign     = 1'($urandom_range(0, 1));
    e.dst              = 5'($urandom_range(0, 31));
    e.mem_addr         = addr;
    e.result           = res;
    e.csr_addr         = 12'($urandom_range(0, 4095));
    e.csr_result       = {$urandom(), $urandom()};
    e.is_ecall         = 1'($urandom_range(0, 1));
    e.is_mret          = 1'($urandom_range(0, 1));
    return e;
  endfunction

  task automatic doAlu(input execute_data_t e, input logic kill, input string tag);
    @(posedge clk); #1;
    dataE = e; valid_in = 1'b1; flush = kill; dresp = '0;
    @(negedge clk);
    total++;
    if (mem_stall !== 1'b0 || dreq.valid !== 1'b0) begin
      bad++; $display("FAIL %s-issue stall=%b dreq.valid=%b want 0/0", tag, mem_stall, dreq.valid);
    end
    @(posedge clk); #1;
    valid_in = 1'b0; flush = 1'b0;
    @(negedge clk);
    total++;
    if (valid_out !== !kill) begin
      bad++; $display("FAIL %s-valid got=%b want=%b", tag, valid_out, !kill);
    end
    if (!kill) begin
      total++;
      if (dataM !== mRetire(e, 64'd0)) begin
        bad++; $display("FAIL %s-data got=%h want=%h", tag, dataM, mRetire(e, 64'd0));
      end
    end
  endtask

  // lat: BUSY cycle (1-based) carrying data_ok; flushAt: BUSY cycle with flush, 0 for none.
  task automatic doMem(input execute_data_t e, input int lat, input int flushAt,
                       input logic [63:0] rdata, input string tag, output logic [7:0] seenStrobe);
    logic killed;
    logic [7:0] xs;
    logic [63:0] xd;
    int stallCnt;
    killed = (flushAt != 0) && (flushAt <= lat);
    xs = mStrobe(e.ctl.op, e.mem_addr);
    xd = mStoreData(e.ctl.op, e.mem_addr, e.result);
    stallCnt = 0;
    seenStrobe = 8'h00;
    @(posedge clk); #1;
    dataE = e; valid_in = 1'b1; flush = 1'b0; dresp = '0;
    @(negedge clk);
    if (mem_stall === 1'b1) stallCnt++;
    total++;
    if (dreq.valid !== 1'b0) begin
      bad++; $display("FAIL %s-early-req got=%b want=0", tag, dreq.valid);
    end
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      flush = (k == flushAt);
      dresp.addr_ok = 1'($urandom_range(0, 1));
      dresp.data_ok = (k == lat);
      dresp.data    = (k == lat) ? rdata : {$urandom(), $urandom()};
      @(negedge clk);
      if (mem_stall === 1'b1) stallCnt++;
      if (k == 1) seenStrobe = dreq.strobe;
      total++;
      if (dreq.valid !== 1'b1 || dreq.addr !== e.mem_addr || dreq.size !== mSize(e.ctl.op) ||
          dreq.strobe !== xs || (mIsSt(e.ctl.op) && dreq.data !== xd)) begin
        bad++;
        $display("FAIL %s-req cyc%0d got v=%b a=%h s=%0d st=%h d=%h want v=1 a=%h s=%0d st=%h d=%h",
                 tag, k, dreq.valid, dreq.addr, dreq.size, dreq.strobe, dreq.data,
                 e.mem_addr, mSize(e.ctl.op), xs, xd);
      end
      total++;
      if (valid_out !== 1'b0) begin
        bad++; $display("FAIL %s-busy-valid cyc%0d got=%b want=0", tag, k, valid_out);
      end
    end
    @(posedge clk); #1;
    valid_in = 1'b0; flush = 1'b0; dresp = '0;
    @(negedge clk);
    total++;
    if (stallCnt !== lat + 1) begin
      bad++; $display("FAIL %s-stall-cycles got=%0d want=%0d", tag, stallCnt, lat + 1);
    end
    total++;
    if (valid_out !== !killed) begin
      bad++; $display("FAIL %s-valid got=%b want=%b", tag, valid_out, !killed);
    end
    if (!killed) begin
      total++;
      if (dataM !== mRetire(e, rdata)) begin
        bad++; $display("FAIL %s-data got=%h want=%h", tag, dataM, mRetire(e, rdata));
      end
    end
    total++;
    if (dreq.valid !== 1'b0 || mem_stall !== 1'b0) begin
      bad++; $display("FAIL %s-release dreq.valid=%b stall=%b want 0/0", tag, dreq.valid, mem_stall);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; valid_in = 1'b0; flush = 1'b0; dresp = '0; dataE = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (valid_out !== 1'b0 || dataM !== '0) begin
      bad++; $display("FAIL reset-out valid=%b dataM=%h want 0/0", valid_out, dataM);
    end
    total++;
    if (dreq !== '0 || mem_stall !== 1'b0) begin
      bad++; $display("FAIL reset-bus dreq=%h stall=%b want 0/0", dreq, mem_stall);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_alu();
    execute_data_t e;
    e = mkInstr(OP_ALU, {$urandom(), $urandom()}, 64'h5);
    doAlu(e, 1'b0, "add");
    total++;
    if (dataM.result !== 64'h5) begin
      bad++; $display("FAIL add-result got=%h want=5", dataM.result);
    end
  endtask

  task automatic test_store_byte();
    execute_data_t e;
    logic [7:0] st;
    e = mkInstr(OP_SB, 64'h8000_0003, 64'hAB);
    doMem(e, 3, 0, {$urandom(), $urandom()}, "sb", st);
    total++;
    if (st !== 8'h08) begin
      bad++; $display("FAIL sb-strobe got=%h want=08", st);
    end
  endtask

  task automatic test_load_sign();
    execute_data_t e;
    logic [7:0] st;
    e = mkInstr(OP_LB, 64'h8000_1005, 64'd0);
    doMem(e, 2, 0, 64'h0000_8000_0000_0000, "lb", st);
    total++;
    if (dataM.result !== 64'hFFFF_FFFF_FFFF_FF80) begin
      bad++; $display("FAIL lb-result got=%h want=ffffffffffffff80", dataM.result);
    end
    e = mkInstr(OP_LBU, 64'h8000_1005, 64'd0);
    doMem(e, 1, 0, 64'h0000_8000_0000_0000, "lbu", st);
    total++;
    if (dataM.result !== 64'h80) begin
      bad++; $display("FAIL lbu-result got=%h want=80", dataM.result);
    end
  endtask

  task automatic test_flush_busy();
    execute_data_t e;
    logic [7:0] st;
    e = mkInstr(OP_LD, 64'h8000_2000, 64'd0);
    doMem(e, 3, 1, {$urandom(), $urandom()}, "ld-drain", st);
    doAlu(mkInstr(OP_ALU, 64'd0, {$urandom(), $urandom()}), 1'b0, "after-drain");
    e = mkInstr(OP_SW, 64'h8000_2004, {$urandom(), $urandom()});
    doMem(e, 2, 2, {$urandom(), $urandom()}, "sw-flush-ok", st);
  endtask

  task automatic test_flush_idle();
    execute_data_t e;
    e = mkInstr(OP_LW, 64'h8000_3008, 64'd0);
    @(posedge clk); #1;
    dataE = e; valid_in = 1'b1; flush = 1'b1;
    @(negedge clk);
    total++;
    if (mem_stall !== 1'b0 || dreq.valid !== 1'b0) begin
      bad++; $display("FAIL idle-flush-issue stall=%b dreq.valid=%b want 0/0", mem_stall, dreq.valid);
    end
    @(posedge clk); #1;
    valid_in = 1'b0; flush = 1'b0;
    @(negedge clk);
    total++;
    if (valid_out !== 1'b0 || dreq.valid !== 1'b0) begin
      bad++; $display("FAIL idle-flush-out valid=%b dreq.valid=%b want 0/0", valid_out, dreq.valid);
    end
    doAlu(mkInstr(OP_ALU, 64'd0, {$urandom(), $urandom()}), 1'b1, "alu-flushed");
  endtask

  task automatic test_reset_busy();
    execute_data_t e;
    e = mkInstr(OP_LD, 64'h8000_4010, 64'd0);
    @(posedge clk); #1;
    dataE = e; valid_in = 1'b1; flush = 1'b0; dresp = '0;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (dreq.valid !== 1'b1) begin
      bad++; $display("FAIL rst-busy-pre dreq.valid got=%b want=1", dreq.valid);
    end
    @(posedge clk); #1;
    reset = 1'b1; valid_in = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; dresp.data_ok = 1'b1; dresp.data = {$urandom(), $urandom()};
    @(negedge clk);
    total++;
    if (dreq.valid !== 1'b0 || mem_stall !== 1'b0 || valid_out !== 1'b0) begin
      bad++; $display("FAIL rst-busy-after dreq.valid=%b stall=%b valid=%b want 0/0/0",
                      dreq.valid, mem_stall, valid_out);
    end
    @(posedge clk); #1;
    dresp = '0;
    @(negedge clk);
    total++;
    if (valid_out !== 1'b0 || dreq.valid !== 1'b0) begin
      bad++; $display("FAIL rst-late-resp valid=%b dreq.valid=%b want 0/0", valid_out, dreq.valid);
    end
  endtask

  task automatic test_misalign();
    execute_data_t e;
`ifdef MISALIGN_TRAP_EN
    for (int t = 0; t < 2; t++) begin
      e = mkInstr((t == 0) ? OP_LW : OP_SW, 64'h8000_5002, {$urandom(), $urandom()});
      @(posedge clk); #1;
      dataE = e; valid_in = 1'b1; flush = 1'b0; dresp = '0;
      @(negedge clk);
      total++;
      if (dreq.valid !== 1'b0 || mem_stall !== 1'b0) begin
        bad++; $display("FAIL trap-issue dreq.valid=%b stall=%b want 0/0", dreq.valid, mem_stall);
      end
      @(posedge clk); #1;
      valid_in = 1'b0;
      @(negedge clk);
      total++;
      if (valid_out !== 1'b1 || dataM.ctl.misalign !== 1'b1 || dataM.result !== 64'h8000_5002 ||
          dataM.ctl.mem_is_store !== (t == 1)) begin
        bad++; $display("FAIL trap-out valid=%b mis=%b st=%b res=%h want 1/1/%0d/80005002",
                        valid_out, dataM.ctl.misalign, dataM.ctl.mem_is_store, dataM.result, t);
      end
    end
`else
    logic [7:0] st;
    e = mkInstr(OP_LW, 64'h8000_5002, 64'd0);
    doMem(e, 2, 0, {$urandom(), $urandom()}, "lw-mis", st);
    total++;
    if (st !== 8'h00) begin
      bad++; $display("FAIL lw-mis-strobe got=%h want=00", st);
    end
    e = mkInstr(OP_SW, 64'h8000_5002, {$urandom(), $urandom()});
    doMem(e, 1, 0, {$urandom(), $urandom()}, "sw-mis", st);
    total++;
    if (st !== 8'h3c) begin
      bad++; $display("FAIL sw-mis-strobe got=%h want=3c", st);
    end
`endif
  endtask

  task automatic test_back_to_back();
    execute_data_t q[$];
    logic kill[$];
    execute_data_t e;
    logic k;
    for (int i = 0; i < 7; i++) begin
      e = mkInstr(OP_ALU, 64'd0, {$urandom(), $urandom()});
      k = ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
      dataE = e; valid_in = 1'b1; flush = k; dresp = '0;
      @(negedge clk);
      if (i > 0) begin
        total++;
        if (valid_out !== !kill[0] || (!kill[0] && dataM !== mRetire(q[0], 64'd0))) begin
          bad++; $display("FAIL b2b-%0d valid=%b data=%h want valid=%b data=%h",
                          i, valid_out, dataM, !kill[0], mRetire(q[0], 64'd0));
        end
        void'(q.pop_front());
        void'(kill.pop_front());
      end
      q.push_back(e);
      kill.push_back(k);
    end
    @(posedge clk); #1;
    valid_in = 1'b0; flush = 1'b0;
    @(negedge clk);
    total++;
    if (valid_out !== !kill[0] || (!kill[0] && dataM !== mRetire(q[0], 64'd0))) begin
      bad++; $display("FAIL b2b-last valid=%b want=%b", valid_out, !kill[0]);
    end
  endtask

  task automatic test_random();
    execute_data_t e;
    decoded_op_t op;
    logic [63:0] addr;
    logic [7:0] st;
    int lat;
    int fl;
    for (int i = 0; i < 40; i++) begin
      op = decoded_op_t'(4'($urandom_range(0, 11)));
      addr = {$urandom(), $urandom()};
`ifdef MISALIGN_TRAP_EN
      addr = addr & ~(64'(mBytes(op)) - 64'd1);
`endif
      e = mkInstr(op, addr, {$urandom(), $urandom()});
      if (op == OP_ALU) begin
        doAlu(e, 1'b0, "rnd-alu");
      end else begin
        lat = $urandom_range(1, 4);
        fl = ($urandom_range(0, 4) == 0) ? $urandom_range(1, lat) : 0;
        doMem(e, lat, fl, {$urandom(), $urandom()}, "rnd-mem", st);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store_byte();
    test_load_sign();
    test_flush_busy();
    test_flush_idle();
    test_reset_busy();
    test_misalign();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
